// File: rtl/ps2_pkg.sv
// PS/2 shared definitions: transmitter states, mouse command bytes,
// device acknowledge code and the frame parity helper.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SEND,
        WAIT_ACK,
        WAIT_RELEASE
    } ps2_tx_state_t;

    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_SET_RATE = 8'hF3;
    localparam logic [7:0] CMD_GET_ID   = 8'hF2;
    localparam logic [7:0] ACK_CODE     = 8'hFA;

    // Falling clock edges in one host frame: 8 data, parity, stop.
    localparam logic [3:0] DATA_EDGES  = 4'd8;
    localparam logic [3:0] PARITY_EDGE = 4'd8;

    // PS/2 uses odd parity over the eight data bits.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_host_transmitter_if.sv
// Command handshake between the mouse init FSM and the transmitter:
// a one-cycle send request with its byte, and busy/done/error status.
interface ps2_host_transmitter_if;

    logic       SEND_BYTE;
    logic [7:0] BYTE_TO_SEND;
    logic       BUSY;
    logic       BYTE_SENT;
    logic       ERROR;

    modport master (
        output SEND_BYTE,
        output BYTE_TO_SEND,
        input  BUSY,
        input  BYTE_SENT,
        input  ERROR
    );

    modport slave (
        input  SEND_BYTE,
        input  BYTE_TO_SEND,
        output BUSY,
        output BYTE_SENT,
        output ERROR
    );

endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the PS/2 clock and data lines plus a
// registered one-cycle strobe on each falling edge of the clock line.
module ps2_line_sync (
    input  logic CLK,
    input  logic RESET,
    input  logic CLK_LINE,
    input  logic DATA_LINE,
    output logic CLK_SYNC,
    output logic DATA_SYNC,
    output logic CLK_FALL
);

    logic [1:0] clk_ff;
    logic [1:0] data_ff;
    logic       clk_prev;

    // Lines idle high, so the chain resets high to avoid a false edge.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            clk_ff   <= 2'b11;
            data_ff  <= 2'b11;
            clk_prev <= 1'b1;
            CLK_FALL <= 1'b0;
        end else begin
            clk_ff   <= {clk_ff[0], CLK_LINE};
            data_ff  <= {data_ff[0], DATA_LINE};
            clk_prev <= clk_ff[1];
            CLK_FALL <= clk_prev & ~clk_ff[1];
        end
    end

    assign CLK_SYNC  = clk_ff[1];
    assign DATA_SYNC = data_ff[1];

endmodule

// File: rtl/ps2_host_transmitter.sv
// PS/2 host-to-device command sender: inhibit, request-to-send, then
// shifts byte/parity/stop on device clock edges and checks the ACK.
module ps2_host_transmitter
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int RTS_CYCLES     = 20,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic CLK,
    input  logic RESET,
    input  logic CLK_MOUSE_IN,
    input  logic DATA_MOUSE_IN,
    output logic CLK_MOUSE_OE,
    output logic DATA_MOUSE_OE,
    ps2_host_transmitter_if.slave bus
);

    localparam logic [31:0] INH_LAST = 32'(INHIBIT_CYCLES - 1);
    localparam logic [31:0] RTS_LAST = 32'(RTS_CYCLES - 1);
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

    logic clk_sync;
    logic data_sync;
    logic clk_fall;

    ps2_line_sync u_sync (
        .CLK       (CLK),
        .RESET     (RESET),
        .CLK_LINE  (CLK_MOUSE_IN),
        .DATA_LINE (DATA_MOUSE_IN),
        .CLK_SYNC  (clk_sync),
        .DATA_SYNC (data_sync),
        .CLK_FALL  (clk_fall)
    );

    ps2_tx_state_t state, state_n;
    logic [31:0]   cnt, cnt_n;
    logic [3:0]    edge_cnt, edge_n;
    logic [7:0]    byte_q, byte_n;
    logic          par_q, par_n;
    logic          clk_oe_q, clk_oe_n;
    logic          data_oe_q, data_oe_n;
    logic          busy_q, busy_n;
    logic          sent_q, sent_n;
    logic          err_q, err_n;
    logic          watched;

    // State, counters and registered line/status outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            cnt       <= '0;
            edge_cnt  <= '0;
            byte_q    <= '0;
            par_q     <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            busy_q    <= 1'b0;
            sent_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            edge_cnt  <= edge_n;
            byte_q    <= byte_n;
            par_q     <= par_n;
            clk_oe_q  <= clk_oe_n;
            data_oe_q <= data_oe_n;
            busy_q    <= busy_n;
            sent_q    <= sent_n;
            err_q     <= err_n;
        end
    end

    // Frame sequencing, bit driving, ACK check and watchdog abort.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        edge_n    = edge_cnt;
        byte_n    = byte_q;
        par_n     = par_q;
        clk_oe_n  = clk_oe_q;
        data_oe_n = data_oe_q;
        sent_n    = 1'b0;
        err_n     = 1'b0;
        watched   = 1'b0;

        unique case (state)
            IDLE: begin
                clk_oe_n  = 1'b0;
                data_oe_n = 1'b0;
                if (bus.SEND_BYTE) begin
                    byte_n   = bus.BYTE_TO_SEND;
                    par_n    = odd_parity(bus.BYTE_TO_SEND);
                    cnt_n    = '0;
                    edge_n   = '0;
                    clk_oe_n = 1'b1;
                    state_n  = INHIBIT;
                end
            end
            INHIBIT: begin
                if (cnt == INH_LAST) begin
                    cnt_n     = '0;
                    data_oe_n = 1'b1;
                    state_n   = RTS;
                end else begin
                    cnt_n = cnt + 32'd1;
                end
            end
            RTS: begin
                if (cnt == RTS_LAST) begin
                    cnt_n    = '0;
                    clk_oe_n = 1'b0;
                    state_n  = SEND;
                end else begin
                    cnt_n = cnt + 32'd1;
                end
            end
            SEND: begin
                watched = 1'b1;
                if (clk_fall) begin
                    edge_n = edge_cnt + 4'd1;
                    if (edge_cnt < DATA_EDGES) begin
                        data_oe_n = ~byte_q[edge_cnt[2:0]];
                    end else if (edge_cnt == PARITY_EDGE) begin
                        data_oe_n = ~par_q;
                    end else begin
                        data_oe_n = 1'b0;
                        state_n   = WAIT_ACK;
                    end
                end
            end
            WAIT_ACK: begin
                watched = 1'b1;
                if (clk_fall) begin
                    if (!data_sync) begin
                        state_n = WAIT_RELEASE;
                    end else begin
                        err_n   = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            WAIT_RELEASE: begin
                watched = 1'b1;
                if (clk_sync && data_sync) begin
                    sent_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: begin
                clk_oe_n  = 1'b0;
                data_oe_n = 1'b0;
                state_n   = IDLE;
            end
        endcase

        if (watched) begin
            if (clk_fall) begin
                cnt_n = '0;
            end else if (state_n == state && cnt == TMO_LAST) begin
                cnt_n     = '0;
                clk_oe_n  = 1'b0;
                data_oe_n = 1'b0;
                err_n     = 1'b1;
                state_n   = IDLE;
            end else begin
                cnt_n = cnt + 32'd1;
            end
        end
    end

    assign busy_n = (state_n != IDLE);

    assign CLK_MOUSE_OE  = clk_oe_q;
    assign DATA_MOUSE_OE = data_oe_q;
    assign bus.BUSY      = busy_q;
    assign bus.BYTE_SENT = sent_q;
    assign bus.ERROR     = err_q;

endmodule

// File: tb/tb_ps2_host_transmitter.sv
// Bench for the PS/2 host transmitter: a PS/2 device model clocks the
// frame, captures bits and ACKs; status is checked every cycle.
module tb_ps2_host_transmitter;

    localparam int INH  = 120;
    localparam int RTSC = 20;
    localparam int TMO  = 1500;
    localparam int H    = 20;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    logic dev_clk = 1'b1;
    logic dev_data = 1'b1;
    logic CLK_MOUSE_IN;
    logic DATA_MOUSE_IN;
    logic CLK_MOUSE_OE;
    logic DATA_MOUSE_OE;

    int checks = 0;
    int errors = 0;
    int n_sent = 0;
    int n_err = 0;
    logic m_busy = 1'b0;
    logic prev_sent = 1'b0;
    logic prev_err = 1'b0;

    ps2_host_transmitter_if bus();

    // Open-drain wired-AND of host and device on each line.
    assign CLK_MOUSE_IN  = dev_clk & ~CLK_MOUSE_OE;
    assign DATA_MOUSE_IN = dev_data & ~DATA_MOUSE_OE;

    ps2_host_transmitter #(
        .INHIBIT_CYCLES (INH),
        .RTS_CYCLES     (RTSC),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .CLK_MOUSE_IN  (CLK_MOUSE_IN),
        .DATA_MOUSE_IN (DATA_MOUSE_IN),
        .CLK_MOUSE_OE  (CLK_MOUSE_OE),
        .DATA_MOUSE_OE (DATA_MOUSE_OE),
        .bus           (bus)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic model_parity(input logic [7:0] b);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return (ones % 2) == 0;
    endfunction

    // Busy model: set by a request while free, ends with a status pulse.
    always @(posedge CLK) begin
        m_busy <= !RESET &&
                  ((m_busy && !(bus.BYTE_SENT || bus.ERROR)) || bus.SEND_BYTE);
    end

    // Per-cycle comparison of status and line outputs.
    always @(negedge CLK) begin
        chk("busy", bus.BUSY, m_busy & ~(bus.BYTE_SENT | bus.ERROR));
        chk("sent_err_excl", bus.BYTE_SENT & bus.ERROR, 0);
        if (!bus.BUSY)
            chk("idle_lines", {CLK_MOUSE_OE, DATA_MOUSE_OE}, 0);
        if (bus.BYTE_SENT) begin
            n_sent++;
            chk("sent_width", prev_sent, 0);
            chk("sent_in_frame", m_busy, 1);
        end
        if (bus.ERROR) begin
            n_err++;
            chk("err_width", prev_err, 0);
            chk("err_in_frame", m_busy, 1);
        end
        prev_sent = bus.BYTE_SENT;
        prev_err  = bus.ERROR;
    end

    task automatic send(input logic [7:0] b);
        @(negedge CLK);
        bus.BYTE_TO_SEND = b;
        bus.SEND_BYTE = 1'b1;
        @(negedge CLK);
        bus.SEND_BYTE = 1'b0;
    endtask

    task automatic wait_rts(output int inh, output int rts);
        inh = 0;
        rts = 0;
        while (CLK_MOUSE_OE && !DATA_MOUSE_OE && inh < INH + 50) begin
            inh++;
            @(negedge CLK);
        end
        while (CLK_MOUSE_OE && DATA_MOUSE_OE && rts < RTSC + 50) begin
            rts++;
            @(negedge CLK);
        end
    endtask

    task automatic dev_clock(input int stop_at, input int poke_at,
                             input bit ack, output logic [9:0] rx);
        rx = '0;
        repeat (H) @(negedge CLK);
        for (int k = 1; k <= 11; k++) begin
            dev_clk = 1'b0;
            if (k == poke_at) begin
                @(negedge CLK);
                bus.BYTE_TO_SEND = 8'h00;
                bus.SEND_BYTE = 1'b1;
                @(negedge CLK);
                bus.SEND_BYTE = 1'b0;
                repeat (H - 2) @(negedge CLK);
            end else begin
                repeat (H) @(negedge CLK);
            end
            if (k == stop_at) return;
            if (k <= 10) rx[k-1] = DATA_MOUSE_IN;
            dev_clk = 1'b1;
            if (k == 10 && ack) dev_data = 1'b0;
            repeat (H) @(negedge CLK);
        end
        dev_data = 1'b1;
    endtask

    task automatic good_frame(input logic [7:0] b, input int poke_at,
                              output logic [9:0] rx);
        int s0, e0, inh, rts;
        s0 = n_sent;
        e0 = n_err;
        send(b);
        wait_rts(inh, rts);
        chk("inhibit_len", inh, INH);
        chk("rts_len", rts, RTSC);
        dev_clock(0, poke_at, 1'b1, rx);
        chk("data_byte", rx[7:0], b);
        chk("parity", rx[8], model_parity(b));
        chk("stop_bit", rx[9], 1);
        repeat (10) @(negedge CLK);
        chk("sent_count", n_sent - s0, 1);
        chk("err_count", n_err - e0, 0);
        chk("busy_after", bus.BUSY, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual running required finished");
        $fatal(1);
    end

    initial begin
        logic [9:0] rx;
        int s0, e0, inh, rts, n;
        bus.SEND_BYTE = 1'b0;
        bus.BYTE_TO_SEND = 8'h00;

        repeat (3) @(negedge CLK);
        chk("rst_clk_oe", CLK_MOUSE_OE, 0);
        chk("rst_data_oe", DATA_MOUSE_OE, 0);
        chk("rst_busy", bus.BUSY, 0);
        chk("rst_pulses", {bus.BYTE_SENT, bus.ERROR}, 0);
        RESET = 1'b0;
        repeat (5) @(negedge CLK);

        good_frame(8'hF4, 0, rx);
        chk("f4_frame", rx, 10'h2F4);

        good_frame(8'hFF, 0, rx);
        chk("ff_frame", rx, 10'h3FF);

        s0 = n_sent;
        e0 = n_err;
        send(8'h5A);
        wait_rts(inh, rts);
        dev_clock(0, 0, 1'b0, rx);
        repeat (10) @(negedge CLK);
        chk("nack_frame", rx, 10'h35A);
        chk("nack_err", n_err - e0, 1);
        chk("nack_sent", n_sent - s0, 0);
        chk("nack_lines", {CLK_MOUSE_OE, DATA_MOUSE_OE}, 0);
        chk("nack_busy", bus.BUSY, 0);

        s0 = n_sent;
        e0 = n_err;
        send(8'h12);
        wait_rts(inh, rts);
        n = 0;
        while (!bus.ERROR && n < TMO + 100) begin
            @(negedge CLK);
            n++;
        end
        chk("timeout_cycles", n, TMO);
        chk("timeout_lines", {CLK_MOUSE_OE, DATA_MOUSE_OE}, 0);
        repeat (5) @(negedge CLK);
        chk("timeout_err", n_err - e0, 1);
        chk("timeout_sent", n_sent - s0, 0);

        good_frame(8'hF3, 4, rx);
        chk("f3_frame", rx, 10'h3F3);

        s0 = n_sent;
        e0 = n_err;
        send(8'hF2);
        wait_rts(inh, rts);
        dev_clock(5, 0, 1'b1, rx);
        RESET = 1'b1;
        @(negedge CLK);
        chk("mid_rst_lines", {CLK_MOUSE_OE, DATA_MOUSE_OE}, 0);
        chk("mid_rst_busy", bus.BUSY, 0);
        RESET = 1'b0;
        dev_clk = 1'b1;
        repeat (20) @(negedge CLK);
        chk("mid_rst_pulses", (n_sent - s0) + (n_err - e0), 0);

        good_frame(8'hF2, 0, rx);
        chk("f2_frame", rx, 10'h2F2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
